// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit common-anode 7-segment
//   display. A 32-bit value written from the bus is latched into a frame
//   shadow at each frame boundary, so a digit never changes in the middle
//   of a frame. Each digit is lit for PERIOD_CYCLES, then all digits are
//   off for DEAD_CYCLES to suppress ghosting. Leading zeros may be blanked.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   wr_en        load wr_data into the display register
//   wr_data      display value, digit i = bits [4i+3:4i]
//   mask_we      load mask_data into the digit-enable mask (takes effect at once)
//   mask_data    bit i = 1 enables digit i
//   lz_en        leading-zero suppression enable (level)
//   scan_nibble  hex value of the current digit, to the segment mapping block
//   scan_blank   1 = segments forced off this cycle
//   dig_en       active-low digit selects, at most one bit low
//   frame_done   one-cycle pulse on the last cycle of each 8-digit frame
//
// States
//   SHOW | current digit idx is selected for PERIOD_CYCLES cycles
//   GAP  | all digits off for DEAD_CYCLES cycles, then advance idx

module seg7_scan_ctrl #(
    parameter int PERIOD_CYCLES = 200000,
    parameter int DEAD_CYCLES   = 1000,
    parameter int NUM_DIGITS    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        mask_we,
    input  logic [7:0]  mask_data,
    input  logic        lz_en,
    output logic [3:0]  scan_nibble,
    output logic        scan_blank,
    output logic [7:0]  dig_en,
    output logic        frame_done
);

    localparam int MAX_PD   = (PERIOD_CYCLES > DEAD_CYCLES) ? PERIOD_CYCLES : DEAD_CYCLES;
    localparam int MAX_CNT  = (MAX_PD > 2) ? MAX_PD : 2;
    localparam int CNT_W    = $clog2(MAX_CNT);
    localparam int IDX_W    = $clog2(NUM_DIGITS);
    localparam bit HAS_GAP  = (DEAD_CYCLES > 0);

    localparam logic [CNT_W-1:0] P_TC     = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] D_TC     = HAS_GAP ? CNT_W'(DEAD_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        disp_q, disp_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [7:0]         mask_q, mask_d;

    logic               show_tc;
    logic               gap_tc;
    logic               digit_adv;
    logic               frame_bnd;
    logic [31:0]        upper;
    logic               suppressed;

    assign show_tc   = (state_q == SHOW) && (cnt_q == P_TC);
    assign gap_tc    = (state_q == GAP)  && (cnt_q == D_TC);
    // With no gap state the digit advances straight out of SHOW.
    assign digit_adv = HAS_GAP ? gap_tc : show_tc;
    assign frame_bnd = digit_adv && (idx_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        disp_d   = wr_en ? wr_data : disp_q;
        mask_d   = mask_we ? mask_data : mask_q;
        // A write landing on the boundary cycle goes straight into the new frame.
        shadow_d = frame_bnd ? (wr_en ? wr_data : disp_q) : shadow_q;

        case (state_q)
            SHOW: begin
                if (show_tc) begin
                    cnt_d = '0;
                    if (HAS_GAP) begin
                        state_d = GAP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_tc) begin
                    cnt_d   = '0;
                    state_d = SHOW;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = SHOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SHOW;
            cnt_q    <= '0;
            idx_q    <= '0;
            disp_q   <= '0;
            shadow_q <= '0;
            mask_q   <= 8'hFF;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
        end
    end

    // Shifting the current digit down to bit 0 gives both the nibble and
    // the "this digit and everything above it is zero" test.
    assign upper       = shadow_q >> {idx_q, 2'b00};
    assign suppressed  = lz_en && (idx_q != '0) && (upper == '0);

    assign scan_nibble = upper[3:0];
    assign scan_blank  = (state_q == GAP) | ~mask_q[idx_q] | suppressed;
    assign dig_en      = scan_blank ? 8'hFF : ~(8'h01 << idx_q);
    assign frame_done  = frame_bnd;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int P  = 4;
    localparam int D  = 1;
    localparam int SL = P + D;
    localparam int FL = 8 * SL;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        mask_we;
    logic [7:0]  mask_data;
    logic        lz_en;
    logic [3:0]  scan_nibble;
    logic        scan_blank;
    logic [7:0]  dig_en;
    logic        frame_done;

    seg7_scan_ctrl #(
        .PERIOD_CYCLES(P),
        .DEAD_CYCLES  (D),
        .NUM_DIGITS   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .mask_we    (mask_we),
        .mask_data  (mask_data),
        .lz_en      (lz_en),
        .scan_nibble(scan_nibble),
        .scan_blank (scan_blank),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         cyc;
        logic [7:0] dig;
        logic       blank;
        logic [3:0] nib;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;
    bit stim_done = 0;

    // Reference model: time since reset plus the architectural registers.
    int          m_t;
    logic [31:0] m_disp;
    logic [31:0] m_shadow;
    logic [7:0]  m_mask;

    task automatic model_reset();
        m_t      = 0;
        m_disp   = 32'h0;
        m_shadow = 32'h0;
        m_mask   = 8'hFF;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Drives one cycle of inputs, queues the expected outputs for that cycle,
    // then advances the model across the clock edge.
    task automatic drive_cycle(input logic r, input logic we, input logic [31:0] wd,
                               input logic mwe, input logic [7:0] md, input logic lz);
        exp_t        e;
        int          pos;
        int          d;
        bit          gap;
        bit          supp;
        logic [31:0] upper;
        rst       = r;
        wr_en     = we;
        wr_data   = wd;
        mask_we   = mwe;
        mask_data = md;
        lz_en     = lz;

        pos   = m_t % FL;
        d     = pos / SL;
        gap   = (pos % SL) >= P;
        upper = m_shadow >> (4 * d);
        supp  = lz && (d != 0) && (upper == 32'h0);

        e.cyc   = edge_cnt;
        e.blank = gap || !m_mask[d] || supp;
        e.dig   = e.blank ? 8'hFF : ~(8'h01 << d);
        e.nib   = upper[3:0];
        e.fd    = (pos == FL - 1);
        exp_q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            if (pos == FL - 1) m_shadow = we ? wd : m_disp;
            if (we)  m_disp = wd;
            if (mwe) m_mask = md;
            m_t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic lz);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 8'h0, lz);
    endtask

    // Idles until the next cycle to be driven sits at frame position 'target'.
    task automatic idle_until(input int target, input logic lz);
        for (int i = 0; i < FL && (m_t % FL) != target; i++)
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 8'h0, lz);
    endtask

    task automatic do_reset();
        drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
    endtask

    // Monitor: every output cycle, compare against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
                e = exp_q.pop_front();
                n_total++;
                $display("FAIL missed_sample cycle=%0d actual=none expected=sample", e.cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
                e = exp_q.pop_front();
                check("dig_en",      {24'h0, dig_en},      {24'h0, e.dig},   e.cyc);
                check("scan_blank",  {31'h0, scan_blank},  {31'h0, e.blank}, e.cyc);
                check("scan_nibble", {28'h0, scan_nibble}, {28'h0, e.nib},   e.cyc);
                check("frame_done",  {31'h0, frame_done},  {31'h0, e.fd},    e.cyc);
            end
        end
    end

    initial begin
        logic        cur_lz;
        logic        r, we, mwe;
        logic [31:0] wd;
        logic [7:0]  md;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; mask_we = 1'b0; mask_data = '0; lz_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset timeline with no writes, two frames.
        idle(2 * FL, 1'b0);

        // Write during frame 0, visible only from the next frame.
        do_reset();
        idle(10, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h1234ABCD, 1'b0, 8'h0, 1'b0);
        idle(2 * FL, 1'b0);

        // Mask change mid-frame takes effect immediately.
        idle_until(7, 1'b0);
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 8'h0F, 1'b0);
        idle(FL + 10, 1'b0);
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 8'hFF, 1'b0);

        // Leading-zero suppression.
        drive_cycle(1'b0, 1'b1, 32'h00000120, 1'b0, 8'h0, 1'b1);
        idle(2 * FL, 1'b1);
        drive_cycle(1'b0, 1'b1, 32'h00000000, 1'b0, 8'h0, 1'b1);
        idle(2 * FL, 1'b1);
        idle(FL, 1'b0);

        // Write landing exactly on the frame_done cycle is bypassed.
        idle_until(FL - 1, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 8'h0, 1'b0);
        idle(FL + 5, 1'b0);

        // Reset during digit 5 SHOW after an earlier mask write; write in the
        // reset cycle must be ignored.
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 8'h3C, 1'b0);
        idle_until(5 * SL + 1, 1'b0);
        drive_cycle(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 8'h00, 1'b0);
        idle(FL + 5, 1'b0);

        // Randomized traffic.
        cur_lz = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) cur_lz = ~cur_lz;
            r   = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 19) == 0);
            mwe = ($urandom_range(0, 29) == 0);
            wd  = $urandom >> $urandom_range(0, 31);
            md  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) md = 8'hFF;
            drive_cycle(r, we, wd, mwe, md, cur_lz);
        end
        idle(5, 1'b0);

        stim_done = 1;
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display.
- Holds a 32-bit display value written from the SoC bus, plus a digit-enable mask.
- Each cycle it presents one hex nibble to the existing hex-to-segment mapping block and drives the active-low digit selects.
- Inserts a dead-time gap between digits to suppress ghosting; optionally suppresses leading zeros.

Parameters:
- PERIOD_CYCLES, 200000: clock cycles each digit is lit (2 ms at 100 MHz).
- DEAD_CYCLES, 1000: all-off gap cycles after each digit; 0 means no gap state.
- NUM_DIGITS, 8: fixed at 8; other values unsupported.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  load wr_data into display register.
- wr_data  in  32  display value; digit i = bits [4i+3:4i].
- mask_we  in  1  load mask_data into mask register.
- mask_data  in  8  bit i = 1 enables digit i.
- lz_en  in  1  leading-zero suppression enable (level, sampled every cycle).
- scan_nibble  out  4  hex value of current digit; feeds the segment mapping block.
- scan_blank  out  1  1 = segments must be forced off this cycle.
- dig_en  out  8  active-low digit selects; at most one bit low.
- frame_done  out  1  one-cycle pulse on the last cycle of each 8-digit frame.

Behaviour:
- One clock, synchronous active-high reset; all state updates on posedge clk.
- Registers:
  - disp_reg[31:0], reset 0.
  - shadow[31:0], reset 0.
  - mask_reg[7:0], reset 8'hFF.
  - idx[2:0], reset 0.
  - cnt, width $clog2(max(PERIOD_CYCLES, DEAD_CYCLES, 2)), reset 0.
  - state, reset SHOW.
- Outputs are decoded combinationally from registers; no extra latency.
- Reset values: dig_en=8'hFE, scan_nibble=0, scan_blank=0, frame_done=0.
- FSM states:
  - SHOW: cnt counts 0..PERIOD_CYCLES-1. At the terminal count, cnt clears; next state is GAP if DEAD_CYCLES>0, otherwise SHOW with idx+1.
  - GAP: cnt counts 0..DEAD_CYCLES-1. At the terminal count, cnt clears and the FSM returns to SHOW with idx+1.
  - idx wraps from 7 to 0.
- Frame boundary: the terminal-count cycle whose transition advances idx from 7 to 0.
  - frame_done=1 on exactly that cycle.
  - On that edge, shadow <= (wr_en ? wr_data : disp_reg). A same-cycle write is bypassed into the next frame.
- Display value:
  - wr_en: disp_reg <= wr_data on the next edge. The displayed value changes only at the next frame boundary (no tearing mid-frame).
  - mask_we: mask_reg <= mask_data on the next edge. Takes effect immediately (not shadowed).
- scan_nibble = shadow[4*idx+3 : 4*idx] in both states.
- Suppression: digit idx is suppressed when lz_en=1, idx!=0, and shadow nibbles idx..7 are all zero. Digit 0 is never suppressed.
- scan_blank = (state==GAP) | ~mask_reg[idx] | suppressed.
- dig_en = scan_blank ? 8'hFF : ~(8'b1 << idx).
- Reset mid-operation: the next cycle is SHOW, idx 0, cnt 0, with shadow, disp_reg and mask_reg restored to reset values. Any write presented in the reset cycle is ignored.
- Simultaneous wr_en and mask_we in one cycle: both registers load.
- Timing constraint: frame length = 8*(PERIOD_CYCLES+DEAD_CYCLES) cycles exactly, independent of the mask and suppression.

Test Plan (PERIOD_CYCLES=4, DEAD_CYCLES=1; cycle 0 = first cycle after reset release):
1. Reset, no writes:
   - cycles 0-3: dig_en=FE, blank=0, nibble=0.
   - cycle 4: dig_en=FF, blank=1.
   - cycles 5-8: dig_en=FD.
   - frame_done high only at cycles 39, 79, ...
2. wr_en with 32'h1234ABCD at cycle 10:
   - nibble stays 0 through cycle 39.
   - cycles 40-43: nibble=D, dig_en=FE.
   - cycles 75-78: nibble=1, dig_en=7F.
3. Data 32'h1234ABCD loaded, then mask_we 8'h0F mid-frame:
   - immediately, digits 4-7 show dig_en=FF, blank=1 during their SHOW windows.
   - digits 0-3 unchanged.
4. Leading-zero suppression:
   - lz_en=1 with shadow 32'h00000120: digits 0,1,2 lit with nibbles 0,2,1; digits 3-7 blank.
   - shadow 0: only digit 0 lit (nibble 0).
5. wr_en 32'hCAFEF00D exactly at cycle 39 (frame_done=1) -> cycles 40-43 show nibble D; digit 7 in that frame shows C.
6. Reset asserted for one cycle during digit 5 SHOW, with a mask_we issued earlier:
   - next cycle: idx 0, dig_en=FE, nibble 0, mask_reg=FF.
   - timeline restarts as in scenario 1.
